datapath_bist: RTL and testbench

//  Parametrised built-in self-test engine for datapath catalog elements.
//  On START, drives a generated stimulus sequence onto a two-operand DUT (A, B).

---
 rtl/bist_pkg.sv | 17 +
 rtl/datapath_bist_poly_shift_reg.sv | 29 ++
 rtl/datapath_bist.sv | 124 ++++++++++++
 tb/tb_datapath_bist.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types for the datapath BIST engine: FSM states, generator modes and
// the mapping from the raw MODE pins onto a generator.
package bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  typedef enum logic [1:0] {M_CNT, M_WALK, M_LFSR} mode_t;

  // Code 3 is an alias for the counting generator.
  function automatic mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return M_WALK;
      2'd2:    return M_LFSR;
      default: return M_CNT;
    endcase
  endfunction

endpackage

// File: rtl/datapath_bist_poly_shift_reg.sv
// Galois shift register with XOR input; serves as stimulus LFSR (din=0)
// and as response MISR (din=C). Load takes priority over shift.
module poly_shift_reg #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] POLY    = 4'b0011,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_nxt;

  assign w_nxt = {r_q[WIDTH-2:0], 1'b0} ^ (r_q[WIDTH-1] ? POLY : '0) ^ i_din;
  assign o_q   = r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_q <= RST_VAL;
    else if (i_load) r_q <= i_load_val;
    else if (i_en)   r_q <= w_nxt;
  end

endmodule

// File: rtl/datapath_bist.sv
// BIST engine: drives generated operands onto a two-operand DUT, folds the
// response into a MISR signature and flags a match against GOLDEN when done.
module datapath_bist
  import bist_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter int               NUM_VECT = 2**WIDTH,
  parameter int               DUT_LAT  = 1,
  parameter logic [WIDTH-1:0] POLY     = 4'b0011
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             START,
  input  logic             ABORT,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] GOLDEN,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SIG,
  output logic             PASS
);

  localparam int IW = $clog2(NUM_VECT + 1);
  localparam int HW = $clog2(DUT_LAT + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_VECT - 1);
  localparam logic [HW-1:0] LAST_HOLD = HW'(DUT_LAT - 1);

  state_t           r_state, w_state_nxt;
  mode_t            r_mode, w_mode_in;
  logic [WIDTH-1:0] r_a, w_a_nxt, w_a_seed, w_lfsr_q;
  logic [IW-1:0]    r_idx;
  logic [HW-1:0]    r_hold;
  logic             w_start, w_cap, w_last, w_busy, w_done;

  assign w_mode_in = decode_mode(MODE);
  // ABORT beats START; START inside RUN is ignored.
  assign w_start   = START && !ABORT && (r_state != RUN);
  assign w_cap     = (r_state == RUN) && !ABORT && (r_hold == LAST_HOLD);
  assign w_last    = w_cap && (r_idx == LAST_IDX);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: if (START && !ABORT) w_state_nxt = RUN;
      RUN: begin
        w_busy = 1'b1;
        if (ABORT)       w_state_nxt = IDLE;
        else if (w_last) w_state_nxt = FIN;
      end
      FIN: begin
        w_done = 1'b1;
        if (ABORT)      w_state_nxt = IDLE;
        else if (START) w_state_nxt = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_a_seed = (w_mode_in == M_CNT) ? '0 : WIDTH'(1);

  always_comb begin
    w_a_nxt = r_a + 1'b1;
    if (r_mode == M_WALK) w_a_nxt = {r_a[WIDTH-2:0], r_a[WIDTH-1]};
  end

  // The final capture does not advance the operand, so A keeps showing the
  // last vector applied once the run is over.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_mode <= M_CNT;
      r_a    <= '0;
      r_idx  <= '0;
      r_hold <= '0;
    end else if (w_start) begin
      r_mode <= w_mode_in;
      r_a    <= w_a_seed;
      r_idx  <= '0;
      r_hold <= '0;
    end else if (w_cap) begin
      r_hold <= '0;
      r_idx  <= r_idx + 1'b1;
      if (!w_last) r_a <= w_a_nxt;
    end else if (r_state == RUN && !ABORT) begin
      r_hold <= r_hold + 1'b1;
    end
  end

  poly_shift_reg #(.WIDTH(WIDTH), .POLY(POLY), .RST_VAL(WIDTH'(1))) u_lfsr (
    .i_clk      (CLK),
    .i_rst_n    (RSTn),
    .i_load     (w_start),
    .i_load_val (WIDTH'(1)),
    .i_en       (w_cap && !w_last),
    .i_din      ('0),
    .o_q        (w_lfsr_q)
  );

  poly_shift_reg #(.WIDTH(WIDTH), .POLY(POLY), .RST_VAL('0)) u_misr (
    .i_clk      (CLK),
    .i_rst_n    (RSTn),
    .i_load     (w_start),
    .i_load_val ('0),
    .i_en       (w_cap),
    .i_din      (C),
    .o_q        (SIG)
  );

  assign A    = (r_mode == M_LFSR) ? w_lfsr_q : r_a;
  assign B    = ~A;
  assign BUSY = w_busy;
  assign DONE = w_done;
  assign PASS = w_done && (SIG == GOLDEN);

endmodule

// File: tb/tb_datapath_bist.sv
// Directed bench for datapath_bist: three engines (16x1, 6x1, 5x3 vectors x hold)
// checked against hand-computed operand sequences and MISR signatures.
module tb_datapath_bist;

  logic       CLK = 1'b0;
  logic       rst0_n, rst2_n, xsel;
  logic       start0, abort0, start1, abort1, start2, abort2;
  logic [1:0] mode0, mode1, mode2;
  logic [3:0] gold0, gold1, gold2;
  logic [3:0] a0, b0, c0, sig0, a1, b1, c1, sig1, a2, b2, c2, sig2;
  logic       busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  assign c0 = xsel ? (a0 ^ b0) : (a0 & b0);
  assign c1 = a1 & b1;
  assign c2 = a2 ^ b2;

  datapath_bist d0 (
    .CLK(CLK), .RSTn(rst0_n), .START(start0), .ABORT(abort0), .MODE(mode0),
    .GOLDEN(gold0), .A(a0), .B(b0), .C(c0), .BUSY(busy0), .DONE(done0),
    .SIG(sig0), .PASS(pass0));

  datapath_bist #(.NUM_VECT(6)) d1 (
    .CLK(CLK), .RSTn(rst0_n), .START(start1), .ABORT(abort1), .MODE(mode1),
    .GOLDEN(gold1), .A(a1), .B(b1), .C(c1), .BUSY(busy1), .DONE(done1),
    .SIG(sig1), .PASS(pass1));

  datapath_bist #(.NUM_VECT(5), .DUT_LAT(3)) d2 (
    .CLK(CLK), .RSTn(rst2_n), .START(start2), .ABORT(abort2), .MODE(mode2),
    .GOLDEN(gold2), .A(a2), .B(b2), .C(c2), .BUSY(busy2), .DONE(done2),
    .SIG(sig2), .PASS(pass2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [3:0] lfsr_tab [15] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                                4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9};
  logic [3:0] walk_tab [6]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};

  initial begin
    logic [3:0] e, eb;
    rst0_n = 1'b0; rst2_n = 1'b0; xsel = 1'b0;
    start0 = 0; abort0 = 0; start1 = 0; abort1 = 0; start2 = 0; abort2 = 0;
    mode0 = 0; mode1 = 0; mode2 = 0; gold0 = 0; gold1 = 0; gold2 = 4'h8;
    #3;
    chk("rst_A", a0, 4'h0);
    chk("rst_B", b0, 4'hF);
    chk("rst_BUSY", busy0, 1'b0);
    chk("rst_DONE", done0, 1'b0);
    chk("rst_SIG", sig0, 4'h0);
    chk("rst_PASS", pass0, 1'b0);
    #4;
    rst0_n = 1'b1; rst2_n = 1'b1;
    step();

    // Counting run, C = A & B = 0
    start0 = 1; step(); start0 = 0;
    for (int k = 0; k < 16; k++) begin
      e = 4'(k); eb = ~e;
      chk("cnt_A", a0, e);
      chk("cnt_B", b0, eb);
      chk("cnt_BUSY", busy0, 1'b1);
      chk("cnt_DONE", done0, 1'b0);
      step();
    end
    chk("cnt_end_DONE", done0, 1'b1);
    chk("cnt_end_BUSY", busy0, 1'b0);
    chk("cnt_end_SIG", sig0, 4'h0);
    chk("cnt_end_PASS", pass0, 1'b1);

    // LFSR run started from FIN; a START mid-run must be ignored
    mode0 = 2'd2; start0 = 1; step(); start0 = 0;
    for (int k = 0; k < 16; k++) begin
      e = lfsr_tab[k % 15]; eb = ~e;
      chk("lfsr_A", a0, e);
      chk("lfsr_B", b0, eb);
      if (k == 7) start0 = 1;
      step();
      start0 = 0;
    end
    chk("lfsr_end_DONE", done0, 1'b1);

    // XOR response, aborted at cycle 5 together with START
    xsel = 1; gold0 = 4'hF; mode0 = 2'd0;
    start0 = 1; step(); start0 = 0;
    repeat (4) step();
    chk("abt_pre_A", a0, 4'h4);
    chk("abt_pre_SIG", sig0, 4'hA);
    abort0 = 1; start0 = 1; step(); abort0 = 0; start0 = 0;
    chk("abt_BUSY", busy0, 1'b0);
    chk("abt_DONE", done0, 1'b0);
    chk("abt_PASS", pass0, 1'b0);
    chk("abt_SIG_kept", sig0, 4'hA);
    chk("abt_A_held", a0, 4'h4);
    step();
    chk("abt_idle_BUSY", busy0, 1'b0);

    start0 = 1; step(); start0 = 0;
    chk("xor_start_SIG", sig0, 4'h0);
    chk("xor_start_A", a0, 4'h0);
    chk("xor_start_BUSY", busy0, 1'b1);
    repeat (15) step();
    chk("xor_c16_DONE", done0, 1'b0);
    step();
    chk("xor_DONE", done0, 1'b1);
    chk("xor_SIG", sig0, 4'hF);
    chk("xor_PASS_F", pass0, 1'b1);
    gold0 = 4'hE; #1;
    chk("xor_PASS_E", pass0, 1'b0);
    gold0 = 4'hF;
    abort0 = 1; step(); abort0 = 0;
    chk("finabt_DONE", done0, 1'b0);
    chk("finabt_SIG", sig0, 4'hF);
    chk("finabt_PASS", pass0, 1'b0);

    // Walking-one, 6 vectors
    mode1 = 2'd1; start1 = 1; step(); start1 = 0;
    for (int k = 0; k < 6; k++) begin
      chk("walk_A", a1, walk_tab[k]);
      chk("walk_DONE", done1, 1'b0);
      step();
    end
    chk("walk_end_DONE", done1, 1'b1);
    chk("walk_end_PASS", pass1, 1'b1);
    chk("walk_end_A", a1, 4'h2);

    // Hold of 3 cycles per vector, async reset mid-run
    start2 = 1; step(); start2 = 0;
    for (int c = 1; c <= 7; c++) begin
      e = 4'((c - 1) / 3); eb = ~e;
      chk("lat_A", a2, e);
      chk("lat_B", b2, eb);
      step();
    end
    chk("lat_BUSY", busy2, 1'b1);
    chk("lat_SIG", sig2, 4'h2);
    #2; rst2_n = 1'b0; #1;
    chk("arst_A", a2, 4'h0);
    chk("arst_B", b2, 4'hF);
    chk("arst_BUSY", busy2, 1'b0);
    chk("arst_DONE", done2, 1'b0);
    chk("arst_SIG", sig2, 4'h0);
    chk("arst_PASS", pass2, 1'b0);
    #1; rst2_n = 1'b1;
    step();
    chk("arst_idle_BUSY", busy2, 1'b0);
    chk("arst_idle_DONE", done2, 1'b0);

    start2 = 1; step(); start2 = 0;
    repeat (14) step();
    chk("lat_c15_DONE", done2, 1'b0);
    chk("lat_c15_BUSY", busy2, 1'b1);
    step();
    chk("lat_DONE", done2, 1'b1);
    chk("lat_end_SIG", sig2, 4'h8);
    chk("lat_end_PASS", pass2, 1'b1);
    chk("lat_end_A", a2, 4'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
